// File: rtl/sr_flag_arbiter.sv
// Purpose: bank of NFLAG set/reset flags written by NREQ requesters via a round-robin arbiter.
// Latency: one edge from an eligible req to ack pulse and flag update; all outputs registered.
// Backpressure: req is held until ack; a requester that sees ack sits out one cycle; clear_all stalls all grants.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int AW    = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         op,
  input  logic [NREQ*AW-1:0]      addr,
  input  logic                    clear_all,
  output logic [NREQ-1:0]         ack,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    err,
  output logic [NFLAG-1:0]        flags
);

  localparam int IDW = $clog2(NREQ);
  // Flag count in a width that can hold the one-past-last address.
  localparam logic [AW:0] NFLAG_W = (AW+1)'(NFLAG);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [NREQ-1:0]  elig;
  logic             any_elig;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic [IDW:0]     scan_idx;
  logic [AW-1:0]    addr_w;
  logic             op_w;
  logic             addr_ok;
  logic [IDW-1:0]   ptr_next;
  logic [NREQ-1:0]  ack_next;
  logic [NFLAG-1:0] flags_next;

  // A requester holding ack this cycle is masked so it is not granted twice while dropping req.
  assign elig     = req & ~ack;
  assign any_elig = |elig;

  // Round-robin pick: scan from the far end back toward ptr so the nearest eligible index wins last.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_idx >= NREQ_W) begin
        scan_idx = scan_idx - NREQ_W;
      end
      if (elig[scan_idx[IDW-1:0]]) begin
        winner = scan_idx[IDW-1:0];
      end
    end
  end

  // Select the winner's operation and flag address.
  always_comb begin
    addr_w = '0;
    op_w   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == winner) begin
        addr_w = addr[i*AW +: AW];
        op_w   = op[i];
      end
    end
  end

  assign addr_ok  = ({1'b0, addr_w} < NFLAG_W);
  assign ptr_next = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;

  // Build the post-write flag vector and the one-hot ack; out-of-range addresses match no flag.
  always_comb begin
    flags_next = flags;
    ack_next   = '0;
    ack_next[winner] = 1'b1;
    for (int f = 0; f < NFLAG; f++) begin
      if ({1'b0, addr_w} == (AW+1)'(f)) begin
        flags_next[f] = op_w;
      end
    end
  end

  // State update: clear_all wins over arbitration, otherwise apply at most one write per edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags       <= '0;
      ack         <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err         <= 1'b0;
      ptr         <= '0;
    end else if (clear_all) begin
      flags       <= '0;
      ack         <= '0;
      grant_valid <= 1'b0;
      err         <= 1'b0;
    end else if (any_elig) begin
      ack         <= ack_next;
      grant_valid <= 1'b1;
      grant_id    <= winner;
      err         <= ~addr_ok;
      flags       <= flags_next;
      ptr         <= ptr_next;
    end else begin
      ack         <= '0;
      grant_valid <= 1'b0;
      err         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed scenarios plus a randomized run against a reference model.
// One edge per tick; outputs sampled 1 time unit after the rising edge.
// Requesters follow the hold-until-ack protocol in directed tests; random traffic is unconstrained.
module tb_sr_flag_arbiter;
  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int AW    = 3;
  localparam int IDW   = $clog2(NREQ);

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*AW-1:0]   addr;
  logic                 clear_all;
  logic [NREQ-1:0]      ack;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 err;
  logic [NFLAG-1:0]     flags;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [NFLAG-1:0] m_flags;
  logic [NREQ-1:0]  m_ack;
  logic             m_gv;
  logic [IDW-1:0]   m_gid;
  logic             m_err;
  int               m_ptr;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr),
    .clear_all(clear_all), .ack(ack), .grant_valid(grant_valid),
    .grant_id(grant_id), .err(err), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_flags = '0; m_ack = '0; m_gv = 1'b0; m_gid = '0; m_err = 1'b0; m_ptr = 0;
  endtask

  // What one rising edge should do, from the current inputs and the previous outputs.
  function automatic void model_edge();
    int w;
    int a;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (w < 0 && req[i] && !m_ack[i]) w = i;
    end
    if (clear_all) begin
      m_flags = '0; m_ack = '0; m_gv = 1'b0; m_err = 1'b0;
    end else if (w >= 0) begin
      m_ack = '0;
      m_ack[w] = 1'b1;
      m_gv = 1'b1;
      m_gid = IDW'(w);
      a = int'(addr[w*AW +: AW]);
      if (a < NFLAG) begin
        m_flags[a] = op[w];
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_ptr = (w + 1) % NREQ;
    end else begin
      m_ack = '0; m_gv = 1'b0; m_err = 1'b0;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0; op = '0; addr = '0; clear_all = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #3;
    reset_n = 1'b1;
  endtask

  task automatic set_addr(input int r, input int a);
    addr[r*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    req = '0; op = '0; addr = '0; clear_all = 1'b0; reset_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({flags, ack, grant_valid, grant_id, err} !== '0) begin
      errors++;
      $display("FAIL reset_initial: flags=%h ack=%b gv=%b gid=%0d err=%b, want all zero",
               flags, ack, grant_valid, grant_id, err);
    end
    reset_n = 1'b1;
    req = '1; op = '1;
    for (int i = 0; i < NREQ; i++) set_addr(i, i);
    tick(); tick(); tick();
    checks++;
    if (ack !== 4'b0100 || ack !== m_ack || flags !== 6'h07) begin
      errors++;
      $display("FAIL reset_stream: ack=%b flags=%h, want ack=0100 flags=07", ack, flags);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({flags, ack, grant_valid, grant_id, err} !== '0) begin
      errors++;
      $display("FAIL reset_async: flags=%h ack=%b gv=%b gid=%0d err=%b, want all zero",
               flags, ack, grant_valid, grant_id, err);
    end
    #2 reset_n = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: ack=%b gid=%0d gv=%b, want ack=0001 gid=0 gv=1",
               ack, grant_id, grant_valid);
    end
    req = '0;
    tick();
  endtask

  task automatic test_single_write();
    apply_reset();
    req = 4'b0100; op = 4'b0100; set_addr(2, 5);
    tick();
    checks++;
    if (ack !== 4'b0100 || flags !== 6'h20 || grant_id !== 2'd2 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_set: ack=%b flags=%h gid=%0d err=%b, want 0100 20 2 0",
               ack, flags, grant_id, err);
    end
    op = 4'b0000;
    tick();
    checks++;
    if (ack !== 4'b0000 || grant_valid !== 1'b0 || flags !== 6'h20) begin
      errors++;
      $display("FAIL single_gap: ack=%b gv=%b flags=%h, want 0000 0 20", ack, grant_valid, flags);
    end
    tick();
    checks++;
    if (ack !== 4'b0100 || flags !== 6'h00) begin
      errors++;
      $display("FAIL single_clear: ack=%b flags=%h, want 0100 00", ack, flags);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  exp_ack [5];
    logic [NFLAG-1:0] exp_flags [5];
    exp_ack   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_flags = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h0F};
    apply_reset();
    req = '1; op = '1;
    for (int i = 0; i < NREQ; i++) set_addr(i, i);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (ack !== exp_ack[c] || flags !== exp_flags[c]) begin
        errors++;
        $display("FAIL round_robin[%0d]: ack=%b flags=%h, want ack=%b flags=%h",
                 c, ack, flags, exp_ack[c], exp_flags[c]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_conflict();
    apply_reset();
    req = 4'b0011; op = 4'b0001; set_addr(0, 3); set_addr(1, 3);
    tick();
    checks++;
    if (ack !== 4'b0001 || flags[3] !== 1'b1) begin
      errors++;
      $display("FAIL conflict_set: ack=%b flags[3]=%b, want 0001 1", ack, flags[3]);
    end
    req = 4'b0010;
    tick();
    checks++;
    if (ack !== 4'b0010 || flags[3] !== 1'b0) begin
      errors++;
      $display("FAIL conflict_clear: ack=%b flags[3]=%b, want 0010 0", ack, flags[3]);
    end
    req = '0;
    tick();
  endtask

  task automatic test_bad_address();
    apply_reset();
    req = 4'b0010; op = 4'b0010; set_addr(1, 5);
    tick();
    req = '0;
    tick();
    req = 4'b0010; set_addr(1, 7);
    tick();
    checks++;
    if (ack !== 4'b0010 || err !== 1'b1 || flags !== 6'h20) begin
      errors++;
      $display("FAIL bad_addr7: ack=%b err=%b flags=%h, want 0010 1 20", ack, err, flags);
    end
    req = '0;
    tick();
    checks++;
    if (ack !== 4'b0000 || err !== 1'b0 || flags !== 6'h20) begin
      errors++;
      $display("FAIL bad_addr_after: ack=%b err=%b flags=%h, want 0000 0 20", ack, err, flags);
    end
    req = 4'b0010; op = 4'b0000; set_addr(1, NFLAG);
    tick();
    checks++;
    if (ack !== 4'b0010 || err !== 1'b1 || flags !== 6'h20) begin
      errors++;
      $display("FAIL bad_addr_edge: ack=%b err=%b flags=%h, want 0010 1 20", ack, err, flags);
    end
    req = '0;
    tick();
  endtask

  task automatic test_clear_all();
    apply_reset();
    for (int a = 0; a < NFLAG; a++) begin
      req = 4'b0001; op = 4'b0001; set_addr(0, a);
      tick();
      req = '0;
      tick();
    end
    checks++;
    if (flags !== 6'h3F) begin
      errors++;
      $display("FAIL clear_fill: flags=%h, want 3f", flags);
    end
    req = 4'b0001; op = 4'b0001; set_addr(0, 2); clear_all = 1'b1;
    tick();
    checks++;
    if (flags !== 6'h00 || ack !== 4'b0000 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_first: flags=%h ack=%b gv=%b, want 00 0000 0", flags, ack, grant_valid);
    end
    tick();
    checks++;
    if (flags !== 6'h00 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL clear_second: flags=%h ack=%b, want 00 0000", flags, ack);
    end
    clear_all = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0001 || flags !== 6'h04) begin
      errors++;
      $display("FAIL clear_release: ack=%b flags=%h, want 0001 04", ack, flags);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req       = NREQ'($urandom);
      op        = NREQ'($urandom);
      addr      = (NREQ*AW)'($urandom);
      clear_all = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if ({flags, ack, grant_valid, grant_id, err} !== {m_flags, m_ack, m_gv, m_gid, m_err}) begin
        errors++;
        $display("FAIL random[%0d]: flags=%h ack=%b gv=%b gid=%0d err=%b, want flags=%h ack=%b gv=%b gid=%0d err=%b",
                 c, flags, ack, grant_valid, grant_id, err, m_flags, m_ack, m_gv, m_gid, m_err);
      end
    end
    req = '0; clear_all = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_conflict();
    test_bad_address();
    test_clear_all();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Shared bank of NFLAG set/reset flags, written by NREQ independent requesters through a round-robin arbiter. Each granted request either sets or clears one addressed flag with SR flip-flop semantics: set forces 1, clear forces 0, no request holds. The block sits between software and hardware event sources and a common status-flag register. It guarantees one flag write per cycle, so set/clear collisions on a flag cannot occur.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of flags in the bank (1..256)
- AW, 3, flag address width; NFLAG <= 2**AW

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request, level, held until ack
- op  input  NREQ  per-requester operation: 1 = set, 0 = clear
- addr  input  NREQ*AW  per-requester flag address; requester i uses bits [i*AW +: AW]
- clear_all  input  1  synchronous bank clear; overrides arbitration
- ack  output  NREQ  one-cycle grant/completion pulse, one-hot or zero
- grant_valid  output  1  a write was applied at the last edge
- grant_id  output  $clog2(NREQ)  index of last granted requester
- err  output  1  one-cycle pulse: last granted addr >= NFLAG
- flags  output  NFLAG  flag bank state

## Operation
- Reset (asynchronous, reset_n low): flags = 0, ack = 0, grant_valid = 0, grant_id = 0, err = 0, round-robin pointer ptr = 0.
- Eligibility: elig = req & ~ack. A requester that sees ack this cycle is not eligible this cycle, which prevents a double grant while it drops req.
- Arbitration (combinational, each cycle): winner = first i with elig[i], scanning ptr, ptr+1, ... mod NREQ.
- At each rising edge where clear_all = 0 and elig != 0:
  - ack[winner] <= 1, all other ack bits <= 0.
  - grant_valid <= 1; grant_id <= winner.
  - If addr_w < NFLAG: flags[addr_w] <= op_w, and err <= 0.
  - Otherwise flags are unchanged and err <= 1.
  - ptr <= (winner + 1) mod NREQ.
- At an edge with elig = 0 and clear_all = 0: ack <= 0, grant_valid <= 0, err <= 0. flags, ptr and grant_id hold.
- clear_all = 1 at an edge: flags <= 0, no grant (ack, grant_valid and err all 0), ptr holds. Pending requests wait.
- Requester protocol: assert req with stable op/addr. Hold until the cycle ack[i] = 1. Req may stay high after ack to issue a new request, which becomes eligible from the following cycle.
- op/addr changes while req is high and ack is not yet seen are undefined usage. The block samples whatever is present at the grant edge.

## Timing
- Latency: req rising edge at cycle t, if it wins, gives flags updated and ack high in cycle t+1 (one edge).
- Throughput: one write per cycle when two or more requesters are pending. A single requester holding req continuously is granted every second cycle.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once per NREQ grants. Worst-case wait is NREQ-1 grants.
- flags, ack, grant_valid, grant_id and err are all registered outputs; there is no combinational input-to-output path.
- Reset mid-operation: all state clears immediately. A request still held after reset release is arbitrated from ptr = 0.

## Test plan
- Reset check: drive all inputs active, pulse reset_n low mid-stream. Required: flags = 0, ack = 0, grant_valid = 0, err = 0 asynchronously. After release, the first grant goes to requester 0.
- Single write: req[2] = 1, op = 1, addr = 5, from reset. Required next cycle: ack = 4'b0100, flags = 8'h20, grant_id = 2. Then op = 0 with the same addr. Required: flags = 8'h00 one cycle after the next grant.
- Round-robin: hold req = 4'b1111, all with distinct addr and op = 1. Required: ack sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and flags accumulate one bit per cycle.
- Conflict: req0 sets flag 3 and req1 clears flag 3, both asserted at the same time with ptr = 0. Required: flags[3] = 1 after the first grant, 0 after the second, never X.
- Bad address: with NFLAG = 6, req[1] = 1, addr = 7. Required: ack[1] pulses, err = 1 for one cycle, flags unchanged.
- clear_all: flags = 8'hFF, req[0] pending, clear_all = 1 for 2 cycles. Required: flags = 0 after the first edge, no ack during clear_all, and ack[0] one cycle after clear_all drops.
